conv_encoder: RTL and testbench
===============================

CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 The block SHALL have parameter K, default 3, meaning constraint length (supported range 3..7).
REQ-002 The block SHALL have parameter G0, default 3'b111 (width K), meaning generator for symbol bit 1; MSB taps the current input bit.
REQ-003 The block SHALL have parameter G1, default 3'b101 (width K), meaning generator for symbol bit 0; MSB taps the current input bit.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning reset, synchronous and active-high.
REQ-006 The block SHALL have port enable, input, 1 bit, meaning clock enable for input acceptance and tail generation.
REQ-007 The block SHALL have port d, input, 1 bit, meaning the information bit.
REQ-008 The block SHALL have port in_valid, input, 1 bit, meaning d and in_last are valid.
REQ-009 The block SHALL have port in_last, input, 1 bit, meaning d is the final bit of the frame.
REQ-010 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts d this cycle.
REQ-011 The block SHALL have port out_sym, output, 2 bits, meaning coded symbol {c0,c1}.
REQ-012 The block SHALL have port out_valid, output, 1 bit, meaning out_sym is valid.
REQ-013 The block SHALL have port out_last, output, 1 bit, meaning out_sym is the final tail symbol of the frame.
REQ-014 The block SHALL have port out_ready, input, 1 bit, meaning the downstream Viterbi decoder takes out_sym this cycle.
REQ-015 The block SHALL have port busy, output, 1 bit, meaning state is not IDLE.

Function
REQ-016 The block SHALL hold a (K-1)-bit state register s, with s[K-2] the most recent bit; tap vector u = {d, s}.
REQ-017 The block SHALL compute c0 = XOR-reduce(G0 & u) and c1 = XOR-reduce(G1 & u), with out_sym[1]=c0 and out_sym[0]=c1.
REQ-018 The block SHALL implement FSM states IDLE, DATA and TAIL.
REQ-019 The block SHALL keep the output slot "free" when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-020 The block SHALL drive in_ready = enable AND slot free AND state in {IDLE, DATA}, as a combinational signal.
REQ-021 On an input transfer (in_valid AND in_ready), the block SHALL register out_sym, set out_valid=1, and shift s <= {d, s[K-2:1]}; latency is one cycle from transfer to out_valid.
REQ-022 The FSM SHALL transition IDLE->DATA on a transfer with in_last=0, and IDLE or DATA->TAIL on a transfer with in_last=1, loading the tail counter with K-1.
REQ-023 In TAIL with enable=1 and slot free, the block SHALL emit one symbol with d=0, shift s, and decrement the tail counter; with K=3 this gives exactly 2 tail symbols.
REQ-024 The block SHALL set out_last=1 only on the final tail symbol, then go to IDLE with s=0.
REQ-025 The block SHALL hold out_sym, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 Output transfer SHALL be independent of enable, and out_valid SHALL clear on transfer unless a new symbol is loaded in the same cycle.
REQ-027 On simultaneous output transfer and new symbol load, the block SHALL sustain back-to-back symbols with no bubble.
REQ-028 With enable=0, the block SHALL accept no input, generate no tail, and leave s and the FSM unchanged.
REQ-029 The block SHALL ignore in_valid during TAIL; in_ready=0 there.
REQ-030 A frame of N bits SHALL produce exactly N+K-1 symbols.

Reset
REQ-031 Reset=1 at a clock edge SHALL set s=0, FSM=IDLE, tail counter=0, out_valid=0, out_last=0, out_sym=2'b00 and busy=0.
REQ-032 Reset SHALL take priority over all other inputs, including mid-frame and mid-tail; the partial frame is discarded with no out_last emitted.

Verification
REQ-033 The bench SHALL cover: K=3, G 111/101, out_ready=1, d=1,0,1,1 with in_last on the 4th bit -> out_sym 11,10,00,01,01,11 on consecutive cycles, out_last only on the 6th, then IDLE.
REQ-034 The bench SHALL cover: same frame with out_ready=0 for 3 cycles after the 2nd symbol -> symbol 10 held stable, in_ready=0, no loss; sequence unchanged.
REQ-035 The bench SHALL cover: enable=0 for 2 cycles during DATA and during TAIL -> no acceptance or tail emission, state held, sequence unchanged.
REQ-036 The bench SHALL cover: reset asserted during the 1st tail symbol -> next cycle out_valid=0, busy=0; new frame d=1,last -> 11,10,11.
REQ-037 The bench SHALL cover: single-bit frame d=0,last -> 00,00,00 with out_last on the 3rd; in_valid held high during TAIL -> not accepted.
REQ-038 The bench SHALL cover: random frames of 1..64 bits with random out_ready -> symbols match the reference model, count = N+2.

Source files
------------

// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with a valid/ready output slot.
// Each accepted information bit yields one 2-bit symbol {c0,c1}. After the
// frame's last bit, K-1 zero bits are pushed through the register so that the
// decoder sees a terminated trellis. The final tail symbol carries out_last.
module conv_encoder #(
  parameter int             K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       d,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [1:0] out_sym,
  output logic       out_valid,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy
);

  localparam int CW = $clog2(K);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  // Parity of the generator-selected taps.
  function automatic logic parity(input logic [K-1:0] g, input logic [K-1:0] u);
    return ^(g & u);
  endfunction

  // Symbol for one input bit given the current shift-register contents.
  function automatic logic [1:0] encode(input logic bit_in, input logic [K-2:0] st);
    logic [K-1:0] u;
    u = {bit_in, st};
    return {parity(G0, u), parity(G1, u)};
  endfunction

  state_t        state, state_nxt;
  logic [K-2:0]  s, s_nxt;
  logic [CW-1:0] tcnt, tcnt_nxt;

  logic          slot_free;
  logic          xfer_in;
  logic          tail_go;
  logic          load_p0;
  logic          bit_p0;
  logic [1:0]    sym_p0;
  logic          last_p0;

  logic [1:0]    sym_p1;
  logic          vld_p1;
  logic          last_p1;

  // ---- stage 0: handshake decode and symbol computation ----
  assign slot_free = !vld_p1 || out_ready;
  assign in_ready  = enable && slot_free && (state != TAIL);
  assign xfer_in   = in_valid && in_ready;
  assign tail_go   = enable && slot_free && (state == TAIL);
  assign load_p0   = xfer_in || tail_go;
  assign bit_p0    = xfer_in ? d : 1'b0;
  assign sym_p0    = encode(bit_p0, s);
  assign last_p0   = tail_go && (tcnt == CW'(1));

  // Next-state logic for the frame FSM, shift register and tail counter.
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    tcnt_nxt  = tcnt;
    case (state)
      IDLE, DATA: begin
        if (xfer_in) begin
          s_nxt = {d, s[K-2:1]};
          if (in_last) begin
            state_nxt = TAIL;
            tcnt_nxt  = CW'(K - 1);
          end else begin
            state_nxt = DATA;
          end
        end
      end
      TAIL: begin
        if (tail_go) begin
          s_nxt    = {1'b0, s[K-2:1]};
          tcnt_nxt = tcnt - CW'(1);
          if (tcnt == CW'(1)) begin
            state_nxt = IDLE;
            s_nxt     = '0;
            tcnt_nxt  = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        s_nxt     = '0;
        tcnt_nxt  = '0;
      end
    endcase
  end

  // State register: FSM, encoder memory and tail counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s     <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nxt;
      s     <= s_nxt;
      tcnt  <= tcnt_nxt;
    end
  end

  // ---- stage 1: output slot, held until the decoder takes it ----
  always_ff @(posedge clk) begin
    if (reset) begin
      sym_p1  <= 2'b00;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else if (load_p0) begin
      sym_p1  <= sym_p0;
      vld_p1  <= 1'b1;
      last_p1 <= last_p0;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end
  end

  assign out_sym   = sym_p1;
  assign out_valid = vld_p1;
  assign out_last  = last_p1;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder (K=3, G0=111, G1=101): cycle table for the basic
// frame, directed stall/enable/reset/single-bit frames, random frames against
// a convolution reference model.
module tb_conv_encoder;

  localparam int         K  = 3;
  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  logic       clk = 1'b0;
  logic       reset, enable, d, in_valid, in_last, out_ready;
  logic       in_ready, out_valid, out_last, busy;
  logic [1:0] out_sym;

  always #5 clk = ~clk;

  conv_encoder #(.K(K), .G0(G0), .G1(G1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .d(d),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_sym(out_sym), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle vector: inputs iv,d,il,en,ordy then expected ev,es,el,in_ready,busy.
  typedef struct packed {
    logic iv, dd, il, en, ordy;
    logic ev;
    logic [1:0] es;
    logic el, eir, eb;
  } vec_t;
  vec_t tbl[8];

  logic       fb[$];    // frame bits
  logic [2:0] got[$];   // observed {last, sym}
  logic [1:0] expq[$];  // reference symbols

  // Reference: sliding-window convolution over the zero-padded bit sequence.
  function automatic void model();
    int n;
    logic c0, c1, x;
    expq.delete();
    n = fb.size();
    for (int i = 0; i < n + K - 1; i++) begin
      c0 = 1'b0;
      c1 = 1'b0;
      for (int j = 0; j < K; j++) begin
        x  = (i - j >= 0 && i - j < n) ? fb[i-j] : 1'b0;
        c0 = c0 ^ (G0[K-1-j] & x);
        c1 = c1 ^ (G1[K-1-j] & x);
      end
      expq.push_back({c0, c1});
    end
  endfunction

  // Drive one frame from fb; collect symbols; compare with the model.
  task automatic run_frame(input bit rnd, input int rdy_s, input int rdy_n,
                           input int en1, input int en2, input bit hold);
    int  idx, cyc, m;
    bit  done, en_off, rdy_off;
    logic       pv, pr, pl;
    logic [1:0] ps;
    idx = 0; cyc = 0; done = 0;
    pv = 0; pr = 0; pl = 0; ps = 0;
    got.delete();
    while (!done && cyc < 3000) begin
      @(negedge clk);
      en_off  = (en1 >= 0 && cyc >= en1 && cyc < en1 + 2) ||
                (en2 >= 0 && cyc >= en2 && cyc < en2 + 2);
      rdy_off = (cyc >= rdy_s && cyc < rdy_s + rdy_n);
      enable    = rnd ? ($urandom_range(0, 7) != 0) : !en_off;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : !rdy_off;
      if (idx < fb.size()) begin
        in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        d        = fb[idx];
        in_last  = (idx == fb.size() - 1);
      end else if (hold && busy) begin
        in_valid = 1'b1; d = 1'b1; in_last = 1'b0;
      end else begin
        in_valid = 1'b0; d = 1'b0; in_last = 1'b0;
      end
      #1;
      if (pv && !pr) begin
        chk("held out_valid", out_valid, 1);
        chk("held out_sym", out_sym, ps);
        chk("held out_last", out_last, pl);
      end
      if (!rnd && en_off) chk("enable-off in_ready", in_ready, 0);
      if (!rnd && rdy_off && out_valid) chk("stall in_ready", in_ready, 0);
      if (idx >= fb.size() && in_valid) chk("tail in_ready", in_ready, 0);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got.push_back({out_last, out_sym});
        if (out_last) done = 1;
      end
      pv = out_valid; pr = out_ready; ps = out_sym; pl = out_last;
      cyc++;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL frame timeout: got %0d symbols expected %0d", got.size(), fb.size() + K - 1);
    end
    @(negedge clk);
    in_valid = 1'b0; enable = 1'b1; out_ready = 1'b1;
    #1;
    chk("post-frame busy", busy, 0);
    chk("post-frame out_valid", out_valid, 0);
    model();
    chk("symbol count", got.size(), expq.size());
    m = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("sym[%0d]", i), got[i][1:0], expq[i]);
      chk($sformatf("last[%0d]", i), got[i][2], (i == expq.size() - 1));
    end
  endtask

  initial begin
    tbl[0] = 11'b11011_0_00_010;
    tbl[1] = 11'b10011_1_11_011;
    tbl[2] = 11'b11011_1_10_011;
    tbl[3] = 11'b11111_1_00_011;
    tbl[4] = 11'b00011_1_01_001;
    tbl[5] = 11'b00011_1_01_001;
    tbl[6] = 11'b00011_1_11_110;
    tbl[7] = 11'b00011_0_00_010;

    reset = 1; enable = 0; d = 0; in_valid = 0; in_last = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_last", out_last, 0);
    chk("reset out_sym", out_sym, 0);
    chk("reset busy", busy, 0);

    // Basic frame 1,0,1,1 cycle by cycle.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      reset = 0;
      in_valid = tbl[i].iv; d = tbl[i].dd; in_last = tbl[i].il;
      enable = tbl[i].en; out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d out_sym", i), out_sym, tbl[i].es);
        chk($sformatf("tbl%0d out_last", i), out_last, tbl[i].el);
      end
      chk($sformatf("tbl%0d in_ready", i), in_ready, tbl[i].eir);
      chk($sformatf("tbl%0d busy", i), busy, tbl[i].eb);
    end

    // Downstream stall of 3 cycles on the 2nd symbol.
    fb = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(0, 2, 3, -1, -1, 0);

    // Enable low for 2 cycles in DATA and 2 cycles in TAIL.
    fb = '{1'b1, 1'b0, 1'b1, 1'b1};
    run_frame(0, -10, 0, 1, 6, 0);

    // Single zero bit, in_valid held high through the tail.
    fb = '{1'b0};
    run_frame(0, -10, 0, -1, -1, 1);

    // Reset during the first tail symbol.
    @(negedge clk);
    enable = 1; out_ready = 1; in_valid = 1; d = 1; in_last = 1;
    #1;
    chk("rst-seq in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0; in_last = 0; d = 0;
    #1;
    chk("rst-seq data sym", out_sym, 3);
    chk("rst-seq data last", out_last, 0);
    @(negedge clk);
    reset = 1;
    #1;
    chk("rst-seq tail1 valid", out_valid, 1);
    chk("rst-seq tail1 sym", out_sym, 2);
    chk("rst-seq tail1 last", out_last, 0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("after reset out_valid", out_valid, 0);
    chk("after reset busy", busy, 0);
    chk("after reset out_last", out_last, 0);
    fb = '{1'b1};
    run_frame(0, -10, 0, -1, -1, 0);

    // Random frames with random handshakes.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(1, 64);
      fb.delete();
      for (int i = 0; i < n; i++) fb.push_back(1'($urandom_range(0, 1)));
      run_frame(1, 0, 0, -1, -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
